// File: rtl/mod_inv.sv
// Sequential modular inverter c = a^(q-2) mod q (Fermat), one modular multiply per clock.
// Fixed-latency square-and-always-multiply over EW exponent bits; mod_mul is its combinational helper.

module mod_mul #(
   parameter logic [22:0] Q0 = 23'd8380417,
   parameter logic [22:0] Q1 = 23'd3329
) (
   input  logic [22:0] a_i,
   input  logic [22:0] b_i,
   input  logic        select_i,
   output logic [22:0] c_c
);
   localparam int unsigned W  = 23;
   localparam int unsigned PW = 2 * W;

   logic [PW-1:0] prod;

   // Each modulus is a constant, so each reduction is a fixed-divisor remainder.
   always_comb begin
      prod = PW'(a_i) * PW'(b_i);
      c_c  = select_i ? W'(prod % PW'(Q1)) : W'(prod % PW'(Q0));
   end
endmodule

module mod_inv #(
   parameter logic [22:0] Q0 = 23'd8380417,
   parameter logic [22:0] Q1 = 23'd3329,
   parameter int unsigned EW = 23
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [22:0] a_i,
   input  logic        select_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [22:0] c_o,
   output logic        err_o
);
   localparam int unsigned W  = 23;
   localparam int unsigned IW = $clog2(EW);
   localparam logic [W-1:0] E0 = Q0 - W'(2);
   localparam logic [W-1:0] E1 = Q1 - W'(2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   r_q, r_d;
   logic [W-1:0]   a_q, a_d;
   logic           sel_q, sel_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   c_q, c_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;

   logic [W-1:0]   q_in;
   logic [W-1:0]   e_sel;
   logic           e_bit;
   logic [W-1:0]   mul_b;
   logic [W-1:0]   p;

   // Squaring reuses r on both multiplier inputs; the multiply step pairs r with a.
   always_comb begin
      q_in  = select_i ? Q1 : Q0;
      e_sel = sel_q ? E1 : E0;
      e_bit = e_sel[idx_q];
      mul_b = (state_q == MUL) ? a_q : r_q;
   end

   mod_mul #(
      .Q0 (Q0),
      .Q1 (Q1)
   ) u_mod_mul (
      .a_i      (r_q),
      .b_i      (mul_b),
      .select_i (sel_q),
      .c_c      (p)
   );

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      a_d     = a_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      c_d     = c_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if ((a_i == '0) || (a_i >= q_in)) begin
                  c_d    = '0;
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  a_d     = a_i;
                  sel_d   = select_i;
                  r_d     = W'(1);
                  idx_d   = IW'(EW - 1);
                  err_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = SQR;
               end
            end
         end
         SQR: begin
            r_d     = p;
            state_d = MUL;
         end
         MUL: begin
            // Product is always formed; only the keep/discard choice depends on the exponent.
            r_d = e_bit ? p : r_q;
            if (idx_q == '0) begin
               c_d     = r_d;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d   = idx_q - IW'(1);
               state_d = SQR;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         r_q     <= '0;
         a_q     <= '0;
         sel_q   <= 1'b0;
         idx_q   <= '0;
         c_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         a_q     <= a_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign c_o    = c_q;
   assign err_o  = err_q;
endmodule

// File: tb/tb_mod_inv.sv
// Self-checking bench for mod_inv: directed cases plus random operands against a
// plain-arithmetic modular exponentiation model.

module tb_mod_inv;
   localparam longint unsigned Q0 = 64'd8380417;
   localparam longint unsigned Q1 = 64'd3329;

   logic        clk_i;
   logic        rst_n_i;
   logic        start_i;
   logic [22:0] a_i;
   logic        select_i;
   logic        busy_o;
   logic        done_o;
   logic [22:0] c_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;

   mod_inv dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .start_i  (start_i),
      .a_i      (a_i),
      .select_i (select_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .c_o      (c_o),
      .err_o    (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic longint unsigned qof(input bit sel);
      return sel ? Q1 : Q0;
   endfunction

   function automatic bit is_valid(input longint unsigned a, input bit sel);
      return (a != 0) && (a < qof(sel));
   endfunction

   // LSB-first binary exponentiation of a^(q-2) mod q.
   function automatic longint unsigned ref_inv(input longint unsigned a, input bit sel);
      longint unsigned q, b, e, r;
      q = qof(sel);
      if (!is_valid(a, sel)) return 0;
      b = a; e = q - 2; r = 1;
      while (e != 0) begin
         if (e[0]) r = (r * b) % q;
         b = (b * b) % q;
         e = e >> 1;
      end
      return r;
   endfunction

   task automatic run_op(input logic [22:0] a, input bit sel, input bit nowait, input bit pulses);
      int unsigned lat;
      bit seen;
      longint unsigned exp_c;
      bit exp_err;
      exp_err = !is_valid(a, sel);
      exp_c   = ref_inv(a, sel);
      if (!nowait) @(negedge clk_i);
      a_i = a; select_i = sel; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (exp_err) begin
         check("err_done", done_o, 1);
         check("err_flag", err_o, 1);
         check("err_c", c_o, 0);
         check("err_busy", busy_o, 0);
         @(posedge clk_i); #1;
         check("err_done_drop", done_o, 0);
         check("err_busy_after", busy_o, 0);
      end else begin
         check("busy_start", busy_o, 1);
         check("done_early", done_o, 0);
         lat = 0; seen = 1'b0;
         while (!seen && lat < 100) begin
            a_i      = 23'($urandom);
            select_i = 1'($urandom);
            if (pulses) start_i = (lat == 5 || lat == 30);
            @(posedge clk_i); #1;
            start_i = 1'b0;
            lat++;
            if (done_o) seen = 1'b1;
            if (lat == 23) check("busy_mid", busy_o, 1);
         end
         check("done_seen", seen, 1);
         check("latency", lat, 46);
         check("result", c_o, exp_c);
         check("err_clear", err_o, 0);
         check("busy_end", busy_o, 0);
      end
   endtask

   initial begin
      int dc;
      rst_n_i = 1'b0; start_i = 1'b0; a_i = '0; select_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_c", c_o, 0);
      check("rst_err", err_o, 0);
      @(negedge clk_i) rst_n_i = 1'b1;

      run_op(23'd17, 1'b1, 1'b0, 1'b0);
      check("t1_const", c_o, 1175);
      run_op(23'd2, 1'b0, 1'b1, 1'b0);
      check("t6_b2b_const", c_o, 4190209);

      run_op(23'd8380416, 1'b0, 1'b0, 1'b0);
      check("t2_const", c_o, 8380416);

      run_op(23'd0, 1'b1, 1'b0, 1'b0);
      run_op(23'd8380417, 1'b0, 1'b0, 1'b0);
      run_op(23'd3329, 1'b1, 1'b0, 1'b0);

      run_op(23'd1, 1'b1, 1'b0, 1'b0);
      check("t4_one", c_o, 1);
      run_op(23'd3, 1'b0, 1'b0, 1'b1);
      check("t4_ignore_start", c_o, 5586945);

      // abort an operation with reset
      @(negedge clk_i);
      a_i = 23'd5; select_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (20) @(posedge clk_i);
      #1;
      rst_n_i = 1'b0;
      #1;
      check("abort_busy", busy_o, 0);
      check("abort_c", c_o, 0);
      check("abort_done", done_o, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_n_i = 1'b1;
      dc = 0;
      repeat (50) begin
         @(posedge clk_i); #1;
         if (done_o) dc++;
      end
      check("abort_no_done", dc, 0);
      run_op(23'd17, 1'b1, 1'b0, 1'b0);
      check("t5_const", c_o, 1175);

      for (int i = 0; i < 20; i++) begin
         bit sel;
         int unsigned mode;
         longint unsigned q;
         logic [22:0] a;
         sel  = 1'($urandom);
         q    = qof(sel);
         mode = $urandom_range(0, 9);
         if (mode == 0) a = '0;
         else if (mode == 1) a = 23'($urandom_range(32'(q), 32'd8388607));
         else a = 23'($urandom_range(1, 32'(q - 1)));
         run_op(a, sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      @(posedge clk_i); #1;
      check("final_done_low", done_o, 0);
      check("final_busy_low", busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
